// File: rtl/cpu_dma_arbiter_pkg.sv
// Shared definitions for cpu_dma_arbiter: FSM state encoding and default bus addresses.
// The DMC_RD state only exists when DMC_DMA_EN is defined.
package cpu_dma_pkg;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] OAM_ADDR_DEF  = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    OAM_RD,
    OAM_WR
`ifdef DMC_DMA_EN
    , DMC_RD
`endif
  } dma_state_e;

endpackage

// File: rtl/cpu_dma_arbiter_if.sv
// Bus bundle between the 6502 core, the DMC channel and the system bus.
// master = arbiter side, slave = core/DMC/memory side.
interface cpu_dma_arbiter_if;

  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mw;
  logic        cpu_ce;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
  logic [7:0]  din;
  logic [15:0] aout;
  logic [7:0]  dout;
  logic        mr;
  logic        mw;
  logic        dma_active;

  modport master (
    input  cpu_aout, cpu_dout, cpu_mw, dmc_req, dmc_addr, din,
    output cpu_ce, dmc_ack, dmc_data, aout, dout, mr, mw, dma_active
  );

  modport slave (
    output cpu_aout, cpu_dout, cpu_mw, dmc_req, dmc_addr, din,
    input  cpu_ce, dmc_ack, dmc_data, aout, dout, mr, mw, dma_active
  );

endinterface

// File: rtl/cpu_dma_arbiter_slot_parity.sv
// Get/put slot parity for the DMA sequencer: a flop toggling on every ce.
// get is high in the cycles where put=0 (read slots).
module dma_slot_parity (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  output logic get
);

  logic put;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      put <= 1'b0;
    end else if (ce) begin
      put <= ~put;
    end
  end

  assign get = ~put;

endmodule

// File: rtl/cpu_dma_arbiter.sv
// cpu_dma_arbiter: shares the 6502 bus between the core, OAM page DMA and DMC sample fetches.
// Define DMC_DMA_EN to enable DMC cycle stealing; otherwise dmc_ack/dmc_data stay 0.
module cpu_dma_arbiter
  import cpu_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] OAM_ADDR  = OAM_ADDR_DEF
) (
  input logic               clk,
  input logic               reset,
  input logic               ce,
  cpu_dma_arbiter_if.master bus
);

  dma_state_e state, state_nxt, svc;
  logic [7:0] page, count, rd_buf;
  logic       oam_pend, pend_after, trig, get;

  dma_slot_parity u_parity (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .get   (get)
  );

`ifndef DMC_DMA_EN
  logic dmc_unused;
  assign dmc_unused = ^{bus.dmc_req, bus.dmc_addr};
`endif

  always_comb begin
    state_nxt    = state;
    trig         = 1'b0;
    bus.aout     = bus.cpu_aout;
    bus.dout     = bus.cpu_dout;
    bus.mw       = 1'b0;
    bus.cpu_ce   = 1'b0;
    bus.dmc_ack  = 1'b0;
    bus.dmc_data = '0;

    // OAM completion is folded in here so the last write can hand over straight to a DMC fetch.
    pend_after = oam_pend;
    if (state == OAM_WR && count == 8'hFF) pend_after = 1'b0;
    svc = pend_after ? OAM_RD : IDLE;
`ifdef DMC_DMA_EN
    if (bus.dmc_req) svc = DMC_RD;
`endif

    unique case (state)
      IDLE: begin
        bus.mw     = bus.cpu_mw;
        bus.cpu_ce = ce;
        if (bus.cpu_mw && bus.cpu_aout == TRIG_ADDR) begin
          trig      = 1'b1;
          state_nxt = HALT;
        end
`ifdef DMC_DMA_EN
        if (bus.dmc_req) state_nxt = HALT;
`endif
      end
      HALT: begin
        if (bus.cpu_mw) begin
          bus.mw     = 1'b1;
          bus.cpu_ce = ce;
        end else begin
          state_nxt = get ? ALIGN : svc;
        end
      end
      ALIGN:  state_nxt = svc;
      OAM_RD: begin
        bus.aout  = {page, count};
        state_nxt = OAM_WR;
      end
      OAM_WR: begin
        bus.aout  = OAM_ADDR;
        bus.dout  = rd_buf;
        bus.mw    = 1'b1;
        state_nxt = svc;
      end
`ifdef DMC_DMA_EN
      DMC_RD: begin
        if (bus.dmc_req) begin
          bus.aout     = bus.dmc_addr;
          bus.dmc_ack  = 1'b1;
          bus.dmc_data = bus.din;
        end
        state_nxt = oam_pend ? ALIGN : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    bus.mr = ~bus.mw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      page     <= '0;
      count    <= '0;
      rd_buf   <= '0;
      oam_pend <= 1'b0;
    end else if (ce) begin
      state    <= state_nxt;
      oam_pend <= trig ? 1'b1 : pend_after;
      if (trig) begin
        page  <= bus.cpu_dout;
        count <= '0;
      end
      if (state == OAM_RD) rd_buf <= bus.din;
      if (state == OAM_WR) count <= count + 8'd1;
    end
  end

  assign bus.dma_active = (state != IDLE);

endmodule

// File: tb/tb_cpu_dma_arbiter.sv
// Directed bench for cpu_dma_arbiter: OAM page copies, DMC steals (when DMC_DMA_EN), reset and ce gating.
`timescale 1ns/1ps
module tb_cpu_dma_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b1;
  logic [31:0] cyc_n;
  int checks = 0;
  int errors = 0;
  int w_active, w_dummy, w_rds, w_wrs, w_dmcs, w_dmc_at, w_err, w_ce_hi, w_done;
  int found, bad;

  cpu_dma_arbiter_if bus ();

  cpu_dma_arbiter #(.TRIG_ADDR(16'h4014), .OAM_ADDR(16'h2004)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  assign bus.din = mem(bus.aout);

  // Independent model of the slot parity: bit 0 of the ce count since reset.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc_n <= '0;
    else if (ce) cyc_n <= cyc_n + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic core_read();
    bus.cpu_mw   = 1'b0;
    bus.cpu_aout = 16'h8000;
    bus.cpu_dout = 8'h00;
  endtask

  task automatic to_slot(input bit want_put);
    @(posedge clk); #1;
    if (cyc_n[0] != want_put) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic trigger(input logic [7:0] pg, input bit slot_put, input bit with_dmc);
    to_slot(slot_put);
    bus.cpu_aout = 16'h4014;
    bus.cpu_dout = pg;
    bus.cpu_mw   = 1'b1;
    bus.dmc_req  = with_dmc;
    @(negedge clk);
    check("trig_pass", 32'({bus.dma_active, bus.cpu_ce, bus.mw, bus.aout, bus.dout}),
          32'({1'b0, 1'b1, 1'b1, 16'h4014, pg}));
    @(posedge clk); #1;
    core_read();
  endtask

  // Follows one DMA from the current cycle until dma_active drops, classifying every bus cycle.
  task automatic watch(input logic [7:0] pg, input int inj);
    logic [7:0] last;
    bit rd_pending;
    bit injected;
    last = '0; rd_pending = 0; injected = 0;
    w_active = 0; w_dummy = 0; w_rds = 0; w_wrs = 0; w_dmcs = 0;
    w_dmc_at = -1; w_err = 0; w_ce_hi = 0; w_done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.dma_active) begin
        w_done = 1;
        break;
      end
      w_active++;
      if (bus.cpu_ce) w_ce_hi++;
      if (bus.mr == bus.mw) w_err++;
      if (bus.mw) begin
        if (!rd_pending || bus.aout != 16'h2004 || bus.dout != last) w_err++;
        rd_pending = 0;
        w_wrs++;
      end else if (bus.dmc_ack) begin
        if (rd_pending || bus.aout != bus.dmc_addr || bus.dmc_data != mem(bus.dmc_addr)) w_err++;
        w_dmcs++;
        w_dmc_at = w_wrs;
      end else if (w_rds < 256 && bus.aout == {pg, w_rds[7:0]}) begin
        if (rd_pending) w_err++;
        last = mem({pg, w_rds[7:0]});
        rd_pending = 1;
        w_rds++;
      end else if (bus.aout == bus.cpu_aout) begin
        if (rd_pending) w_err++;
        w_dummy++;
      end else begin
        w_err++;
      end
      @(posedge clk); #1;
      if (inj >= 0 && !injected && w_rds == inj) begin
        bus.dmc_req = 1'b1;
        injected = 1;
      end
      if (w_dmcs > 0) bus.dmc_req = 1'b0;
    end
  endtask

  task automatic check_run(input string t, input int act, input int dum, input int nrd,
                           input int ndmc, input int dmc_at);
    check({t, "_done"},    w_done, 1);
    check({t, "_active"},  w_active, act);
    check({t, "_dummy"},   w_dummy, dum);
    check({t, "_reads"},   w_rds, nrd);
    check({t, "_writes"},  w_wrs, nrd);
    check({t, "_dmc"},     w_dmcs, ndmc);
    check({t, "_dmc_at"},  w_dmc_at, dmc_at);
    check({t, "_seq_err"}, w_err, 0);
    check({t, "_ce_hi"},   w_ce_hi, 0);
    check({t, "_resume"},  32'({bus.cpu_ce, bus.mw, bus.aout}), 32'({1'b1, 1'b0, bus.cpu_aout}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_aout = 16'h1234;
    bus.cpu_dout = 8'hAB;
    bus.cpu_mw   = 1'b1;
    bus.dmc_req  = 1'b0;
    bus.dmc_addr = 16'hC000;
    #1 reset = 1'b1;
    #11;
    check("reset_ctl", 32'({bus.dma_active, bus.cpu_ce, bus.mw, bus.mr, bus.dmc_ack}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    check("reset_bus", 32'({bus.aout, bus.dout, bus.dmc_data}), 32'({16'h1234, 8'hAB, 8'h00}));
    @(negedge clk);
    reset = 1'b0;
    core_read();

    // HALT on a get slot: HALT + ALIGN + 512.
    trigger(8'h02, 1'b1, 1'b0);
    watch(8'h02, -1);
    check_run("oam_get", 514, 2, 256, 0, -1);

    // Core still writing when HALT is entered: the write passes, the halt starts on the next read.
    trigger(8'h05, 1'b0, 1'b0);
    bus.cpu_aout = 16'h0300;
    bus.cpu_dout = 8'h77;
    bus.cpu_mw   = 1'b1;
    @(negedge clk);
    check("halt_write", 32'({bus.dma_active, bus.cpu_ce, bus.mw, bus.mr, bus.aout, bus.dout}),
          32'({1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 8'h77}));
    @(posedge clk); #1;
    core_read();
    watch(8'h05, -1);
    check_run("oam_hw", 514, 2, 256, 0, -1);

`ifdef DMC_DMA_EN
    bus.dmc_addr = 16'hC000;
    to_slot(1'b0);
    bus.dmc_req = 1'b1;
    @(posedge clk); #1;
    watch(8'h02, -1);
    check_run("dmc_put", 2, 1, 0, 1, 0);

    to_slot(1'b1);
    bus.dmc_req = 1'b1;
    @(posedge clk); #1;
    watch(8'h02, -1);
    check_run("dmc_get", 3, 2, 0, 1, 0);

    to_slot(1'b0);
    bus.dmc_req = 1'b1;
    @(posedge clk); #1;
    bus.dmc_req = 1'b0;
    watch(8'h02, -1);
    check_run("dmc_drop", 1, 1, 0, 0, -1);

    trigger(8'h02, 1'b1, 1'b0);
    watch(8'h02, 8'h40);
    check_run("oam_steal", 516, 3, 256, 1, 64);

    trigger(8'h04, 1'b1, 1'b1);
    watch(8'h04, -1);
    check_run("oam_dmc_same", 516, 3, 256, 1, 0);
`else
    to_slot(1'b0);
    bus.dmc_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.dma_active || bus.dmc_ack || bus.dmc_data != 8'h00 || !bus.cpu_ce) bad++;
    end
    check("dmc_ignored", bad, 0);
    bus.dmc_req = 1'b0;
`endif

    trigger(8'h06, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.aout == 16'h0680) begin
        found = 1;
        break;
      end
    end
    check("mid_reach", found, 1);
    ce  = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.aout != 16'h0680 || bus.cpu_ce || !bus.dma_active) bad++;
    end
    check("ce_hold", bad, 0);
    ce = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_reset", 32'({bus.dma_active, bus.cpu_ce, bus.mw, bus.dmc_ack, bus.aout}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 16'h8000}));
    @(negedge clk);
    reset = 1'b0;

    // HALT on a put slot: no ALIGN, 513 cycles.
    trigger(8'h03, 1'b0, 1'b0);
    watch(8'h03, -1);
    check_run("oam_put", 513, 1, 256, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
